// File: rtl/regfile_pkg.sv
// regfile_pkg: shared width default, address-width helper and dump state encoding
package regfile_pkg;
  localparam int XLEN_DEF = 64;
  function automatic int aw_of(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  typedef enum logic [1:0] {DUMP_IDLE, DUMP_RUN, DUMP_DONE} dump_state_t;
endpackage

// File: rtl/regfile_dump_fsm.sv
// regfile_dump_fsm: handshaked index walker that streams register indices 0..NREGS-1
module regfile_dump_fsm
  import regfile_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          dump_req,
  input  logic          dump_ready,
  output logic          dump_valid,
  output logic          dump_done,
  output logic [AW-1:0] dump_idx
);
  dump_state_t state, state_nx;
  logic [AW-1:0] idx_nx;
  logic fire, last;
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= DUMP_IDLE;
      dump_idx <= '0;
    end else begin
      state    <= state_nx;
      dump_idx <= idx_nx;
    end
  end
  always_comb begin
    fire       = state == DUMP_RUN && dump_ready;
    last       = dump_idx == AW'(NREGS - 1);
    state_nx   = state == DUMP_IDLE ? (dump_req ? DUMP_RUN : DUMP_IDLE)
               : state == DUMP_RUN  ? (fire && last ? DUMP_DONE : DUMP_RUN)
               : DUMP_IDLE;
    idx_nx     = fire ? (last ? '0 : dump_idx + AW'(1)) : dump_idx;
    dump_valid = state == DUMP_RUN;
    dump_done  = state == DUMP_DONE;
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with priority writes, bypass, busy scoreboard and dump port
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREGS = 32,
  parameter int NRD = 2,
  parameter int NWR = 2,
  parameter int BYPASS = 1,
  localparam int AW = aw_of(NREGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NRD*AW-1:0] rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]    rd_busy,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic              alloc_en,
  input  logic [AW-1:0]     alloc_addr,
  input  logic              dump_req,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [AW-1:0]     dump_idx,
  output logic [XLEN-1:0]   dump_data,
  output logic              dump_done
);
  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] busy;
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
      busy <= '0;
    end else begin
      for (int w = 0; w < NWR; w++) begin
        if (wr_en[w] && wr_addr[w*AW +: AW] != '0) begin
          regs[wr_addr[w*AW +: AW]] <= wr_data[w*XLEN +: XLEN];
          busy[wr_addr[w*AW +: AW]] <= 1'b0;
        end
      end
      if (alloc_en && alloc_addr != '0) busy[alloc_addr] <= 1'b1;
    end
  end
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int p = 0; p < NRD; p++) begin
      rd_data[p*XLEN +: XLEN] = regs[rd_addr[p*AW +: AW]];
      rd_busy[p] = busy[rd_addr[p*AW +: AW]];
      for (int w = 0; w < NWR; w++) begin
        if (BYPASS != 0 && wr_en[w] && rd_addr[p*AW +: AW] != '0 &&
            wr_addr[w*AW +: AW] == rd_addr[p*AW +: AW])
          rd_data[p*XLEN +: XLEN] = wr_data[w*XLEN +: XLEN];
      end
    end
  end
  assign dump_data = regs[dump_idx];
  regfile_dump_fsm #(.NREGS(NREGS), .AW(AW)) u_dump (
    .clk(clk),
    .reset(reset),
    .dump_req(dump_req),
    .dump_ready(dump_ready),
    .dump_valid(dump_valid),
    .dump_done(dump_done),
    .dump_idx(dump_idx)
  );
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed self-checking bench for regfile_mp
module tb_regfile_mp;
  localparam int XLEN = 64;
  localparam int AW = 5;
  logic clk = 0;
  logic reset;
  logic [2*AW-1:0] rd_addr;
  logic [2*XLEN-1:0] rd_data;
  logic [1:0] rd_busy;
  logic [1:0] wr_en;
  logic [2*AW-1:0] wr_addr;
  logic [2*XLEN-1:0] wr_data;
  logic alloc_en;
  logic [AW-1:0] alloc_addr;
  logic dump_req, dump_valid, dump_ready, dump_done;
  logic [AW-1:0] dump_idx;
  logic [XLEN-1:0] dump_data;
  int n_checks = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  regfile_mp dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .alloc_en(alloc_en),
    .alloc_addr(alloc_addr), .dump_req(dump_req), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_idx(dump_idx), .dump_data(dump_data), .dump_done(dump_done)
  );
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive_wr(input logic [1:0] en, input int a0, input int a1,
                          input logic [XLEN-1:0] d0, input logic [XLEN-1:0] d1);
    wr_en = en;
    wr_addr = {AW'(a1), AW'(a0)};
    wr_data = {d1, d0};
  endtask
  task automatic test_reset();
    reset = 1;
    step();
    step();
    reset = 0;
    for (int r = 0; r < 32; r++) begin
      rd_addr = {AW'(r), AW'(r)};
      #1;
      n_checks++;
      if (rd_data !== '0 || rd_busy !== 2'b00) begin
        n_fail++;
        $display("FAIL reset_read reg%0d: got data=%h busy=%b, want 0/00", r, rd_data, rd_busy);
      end
    end
    n_checks++;
    if (dump_valid !== 1'b0 || dump_idx !== '0 || dump_done !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_dump: got valid=%b idx=%0d done=%b, want 0/0/0", dump_valid, dump_idx, dump_done);
    end
  endtask
  task automatic test_write_priority();
    drive_wr(2'b11, 5, 5, 64'hDEAD_BEEF, 64'h1234);
    rd_addr = {AW'(0), AW'(5)};
    #1;
    n_checks++;
    if (rd_data[XLEN-1:0] !== 64'h1234) begin
      n_fail++;
      $display("FAIL bypass_prio: got %h, want %h", rd_data[XLEN-1:0], 64'h1234);
    end
    step();
    drive_wr(2'b01, 6, 0, 64'hDEAD_BEEF, 64'h0);
    rd_addr = {AW'(5), AW'(6)};
    #1;
    n_checks++;
    if (rd_data[XLEN-1:0] !== 64'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL bypass_single: got %h, want %h", rd_data[XLEN-1:0], 64'hDEAD_BEEF);
    end
    n_checks++;
    if (rd_data[2*XLEN-1:XLEN] !== 64'h1234) begin
      n_fail++;
      $display("FAIL write_prio: got %h, want %h", rd_data[2*XLEN-1:XLEN], 64'h1234);
    end
    step();
    drive_wr(2'b00, 0, 0, 64'h0, 64'h0);
    #1;
    n_checks++;
    if (rd_data !== {64'h1234, 64'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL stored_read: got %h, want %h", rd_data, {64'h1234, 64'hDEAD_BEEF});
    end
  endtask
  task automatic test_reg0();
    drive_wr(2'b11, 0, 0, 64'hFFFF, 64'hFFFF);
    alloc_en = 1;
    alloc_addr = '0;
    rd_addr = '0;
    #1;
    n_checks++;
    if (rd_data !== '0) begin
      n_fail++;
      $display("FAIL reg0_bypass: got %h, want 0", rd_data);
    end
    step();
    drive_wr(2'b00, 0, 0, 64'h0, 64'h0);
    alloc_en = 0;
    #1;
    n_checks++;
    if (rd_data !== '0 || rd_busy !== 2'b00) begin
      n_fail++;
      $display("FAIL reg0_stored: got data=%h busy=%b, want 0/00", rd_data, rd_busy);
    end
  endtask
  task automatic test_busy();
    alloc_en = 1;
    alloc_addr = 7;
    rd_addr = {AW'(9), AW'(7)};
    #1;
    n_checks++;
    if (rd_busy !== 2'b00) begin
      n_fail++;
      $display("FAIL busy_pre_edge: got %b, want 00", rd_busy);
    end
    step();
    alloc_en = 0;
    #1;
    n_checks++;
    if (rd_busy !== 2'b01) begin
      n_fail++;
      $display("FAIL busy_alloc: got %b, want 01", rd_busy);
    end
    drive_wr(2'b10, 0, 7, 64'h0, 64'h77);
    #1;
    n_checks++;
    if (rd_busy !== 2'b01) begin
      n_fail++;
      $display("FAIL busy_not_bypassed: got %b, want 01", rd_busy);
    end
    step();
    drive_wr(2'b01, 9, 0, 64'h99, 64'h0);
    alloc_en = 1;
    alloc_addr = 9;
    #1;
    n_checks++;
    if (rd_busy !== 2'b00) begin
      n_fail++;
      $display("FAIL busy_clear: got %b, want 00", rd_busy);
    end
    step();
    drive_wr(2'b00, 0, 0, 64'h0, 64'h0);
    alloc_en = 0;
    #1;
    n_checks++;
    if (rd_busy !== 2'b10 || rd_data !== {64'h99, 64'h77}) begin
      n_fail++;
      $display("FAIL busy_alloc_wins: got busy=%b data=%h, want 10/%h", rd_busy, rd_data, {64'h99, 64'h77});
    end
    drive_wr(2'b01, 9, 0, 64'h99, 64'h0);
    step();
    drive_wr(2'b00, 0, 0, 64'h0, 64'h0);
  endtask
  task automatic load_regs();
    for (int i = 0; i < 32; i += 2) begin
      drive_wr(2'b11, i, i + 1, 64'(i * 16), 64'((i + 1) * 16));
      step();
    end
    drive_wr(2'b00, 0, 0, 64'h0, 64'h0);
  endtask
  task automatic test_dump();
    int exp_idx;
    int done_cnt;
    logic rdy;
    load_regs();
    dump_ready = 0;
    dump_req = 1;
    step();
    dump_req = 0;
    n_checks++;
    if (dump_valid !== 1'b1 || dump_idx !== '0 || dump_data !== 64'h0) begin
      n_fail++;
      $display("FAIL dump_first_beat: got valid=%b idx=%0d data=%h, want 1/0/0", dump_valid, dump_idx, dump_data);
    end
    exp_idx = 0;
    done_cnt = 0;
    rdy = 1;
    for (int c = 0; c < 200 && done_cnt == 0; c++) begin
      dump_ready = rdy;
      if (c == 5) dump_req = 1;
      if (c == 6) dump_req = 0;
      #1;
      if (dump_done === 1'b1) done_cnt++;
      else if (dump_valid === 1'b1) begin
        n_checks++;
        if (dump_idx !== AW'(exp_idx) || dump_data !== 64'(exp_idx * 16)) begin
          n_fail++;
          $display("FAIL dump_beat: got idx=%0d data=%h, want idx=%0d data=%h", dump_idx, dump_data, exp_idx, 64'(exp_idx * 16));
        end
        if (rdy) exp_idx++;
      end
      rdy = !rdy;
      step();
    end
    dump_ready = 0;
    n_checks++;
    if (exp_idx !== 32 || done_cnt !== 1) begin
      n_fail++;
      $display("FAIL dump_count: got beats=%0d done=%0d, want 32/1", exp_idx, done_cnt);
    end
    n_checks++;
    if (dump_valid !== 1'b0 || dump_done !== 1'b0) begin
      n_fail++;
      $display("FAIL dump_idle: got valid=%b done=%b, want 0/0", dump_valid, dump_done);
    end
  endtask
  task automatic test_reset_mid_dump();
    int done_seen;
    dump_ready = 1;
    dump_req = 1;
    step();
    dump_req = 0;
    for (int c = 0; c < 50 && dump_idx != AW'(10); c++) step();
    n_checks++;
    if (dump_idx !== AW'(10) || dump_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reach_beat10: got idx=%0d valid=%b, want 10/1", dump_idx, dump_valid);
    end
    reset = 1;
    step();
    n_checks++;
    if (dump_valid !== 1'b0 || dump_done !== 1'b0 || dump_idx !== '0) begin
      n_fail++;
      $display("FAIL abort_dump: got valid=%b done=%b idx=%0d, want 0/0/0", dump_valid, dump_done, dump_idx);
    end
    reset = 0;
    done_seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (dump_done !== 1'b0 || dump_valid !== 1'b0) done_seen++;
      step();
    end
    n_checks++;
    if (done_seen !== 0) begin
      n_fail++;
      $display("FAIL abort_no_done: got %0d active cycles, want 0", done_seen);
    end
    for (int r = 0; r < 32; r++) begin
      rd_addr = {AW'(r), AW'(r)};
      #1;
      n_checks++;
      if (rd_data !== '0 || rd_busy !== 2'b00) begin
        n_fail++;
        $display("FAIL abort_regs reg%0d: got data=%h busy=%b, want 0/00", r, rd_data, rd_busy);
      end
    end
  endtask
  initial begin
    reset = 1;
    rd_addr = '0;
    wr_en = '0;
    wr_addr = '0;
    wr_data = '0;
    alloc_en = 0;
    alloc_addr = '0;
    dump_req = 0;
    dump_ready = 0;
    test_reset();
    test_write_priority();
    test_reg0();
    test_busy();
    test_dump();
    test_reset_mid_dump();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
